// File: rtl/multiplicador_algoritmico_if.sv
// Start/Done handshake and operand/result bus of the Booth multiplier.
//   Start    : request to begin a multiplication (master -> slave)
//   A, B     : signed multiplicand and multiplier (master -> slave)
//   Producto : signed product, registered (slave -> master)
//   Done     : high while Producto holds a valid result (slave -> master)
interface multiplicador_algoritmico_if #(
    parameter int tamanyo = 32
);
    logic                     Start;
    logic [tamanyo-1:0]       A;
    logic [tamanyo-1:0]       B;
    logic [2*tamanyo-1:0]     Producto;
    logic                     Done;

    modport master (
        output Start, A, B,
        input  Producto, Done
    );

    modport slave (
        input  Start, A, B,
        output Producto, Done
    );
endinterface

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed multiplier, radix-2 Booth, one Booth step every two
// clock cycles (evaluate, then shift). Shares the Start/Done handshake of
// the iterative divider.
//   CLK  : system clock, rising edge
//   RSTa : asynchronous active-low reset
//   bus  : slave side of multiplicador_algoritmico_if (Start, A, B in;
//          Producto, Done out)
// Latency: Start accepted at edge k -> Done/Producto valid after edge
// k + 2*tamanyo + 1. Done is a level held until the next accepted Start.
module multiplicador_algoritmico #(
    parameter int tamanyo = 32,
    parameter int t_mod   = 5
) (
    input  logic                         CLK,
    input  logic                         RSTa,
    multiplicador_algoritmico_if.slave   bus
);

    typedef enum logic [1:0] {M0, M1, M2, M3} estado_t;

    estado_t                estado;
    // One guard bit on accu and m keeps -2^(tamanyo-1) operands from
    // overflowing when m is subtracted.
    logic [tamanyo:0]       accu;
    logic [tamanyo:0]       m;
    logic [tamanyo-1:0]     q;
    logic                   q_1;
    logic [t_mod-1:0]       cont;
    logic [2*tamanyo-1:0]   producto;
    logic                   done;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            estado   <= M0;
            accu     <= '0;
            m        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            cont     <= '0;
            producto <= '0;
            done     <= 1'b0;
        end else begin
            case (estado)
                M0: begin
                    // Operands are captured only here, so later changes on
                    // A/B cannot disturb an operation in flight.
                    if (bus.Start) begin
                        accu   <= '0;
                        m      <= {bus.A[tamanyo-1], bus.A};
                        q      <= bus.B;
                        q_1    <= 1'b0;
                        cont   <= t_mod'(tamanyo - 1);
                        done   <= 1'b0;
                        estado <= M1;
                    end
                end
                M1: begin
                    case ({q[0], q_1})
                        2'b01:   accu <= accu + m;
                        2'b10:   accu <= accu - m;
                        default: accu <= accu;
                    endcase
                    estado <= M2;
                end
                M2: begin
                    // Arithmetic shift of the whole {accu,q,q_1} chain.
                    {accu, q, q_1} <= {accu[tamanyo], accu, q};
                    if (cont == '0) begin
                        estado <= M3;
                    end else begin
                        cont   <= cont - t_mod'(1);
                        estado <= M1;
                    end
                end
                M3: begin
                    producto <= {accu[tamanyo-1:0], q};
                    done     <= 1'b1;
                    estado   <= M0;
                end
                default: estado <= M0;
            endcase
        end
    end

    assign bus.Producto = producto;
    assign bus.Done     = done;

endmodule

// File: doc/multiplicador_algoritmico.md
Name: multiplicador_algoritmico

Overview:
- Sequential signed multiplier using the radix-2 Booth algorithm.
- Forms the inverse arithmetic path to the team's iterative divider and shares its Start/Done handshake and multicycle timing style.
- Multiplies two tamanyo-bit two's-complement operands into a 2*tamanyo-bit two's-complement product.
- Processes one Booth step per two clock cycles.

Parameters:
- tamanyo, 32, operand width in bits (≥ 2).
- t_mod, 5, iteration counter width; requires 2^t_mod ≥ tamanyo.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTa  input  1  asynchronous active-low reset.
- Start  input  1  request pulse or level; sampled only in idle state.
- A  input  tamanyo  multiplicand, signed two's complement.
- B  input  tamanyo  multiplier, signed two's complement.
- Producto  output  2*tamanyo  signed product A*B; registered.
- Done  output  1  high while Producto holds a valid result.

Behaviour:
- Reset (RSTa=0, asynchronous):
  - state=M0, Producto=0, Done=0, internal registers 0.
  - Applies mid-operation too; the in-flight result is discarded.
- Internal registers:
  - ACCU: tamanyo+1 bits, sign-extended.
  - M: tamanyo+1 bits, sign-extended copy of A.
  - Q: tamanyo bits.
  - Q_1: 1 bit.
  - CONT: t_mod bits.
  - Extra ACCU/M bit is mandatory so that A = -2^(tamanyo-1) is handled without overflow.
- State M0 (idle):
  - If Start=1 at an edge: ACCU←0, M←sext(A), Q←B, Q_1←0, CONT←tamanyo-1, Done←0, go to M1.
  - Otherwise stay in M0; Producto and Done hold.
- State M1 (evaluate):
  - {Q[0],Q_1} = 01: ACCU←ACCU+M.
  - {Q[0],Q_1} = 10: ACCU←ACCU-M.
  - 00 or 11: no change.
  - Always go to M2.
- State M2 (shift):
  - Arithmetic right shift of {ACCU,Q,Q_1} by one; ACCU MSB is replicated.
  - If CONT=0: go to M3.
  - Else: CONT←CONT-1, go to M1.
- State M3 (finish):
  - Producto←{ACCU[tamanyo-1:0],Q}, Done←1, go to M0.
- Latency:
  - Start sampled at edge k → Done and Producto valid after edge k+2*tamanyo+1.
  - Example: 17 cycles for tamanyo=8.
- Done is a level:
  - Stays 1 and Producto stays stable until the next accepted Start.
  - Done clears on the accepting edge; Producto keeps the old value until overwritten in M3.
- Start while busy (M1–M3): ignored; no restart, no effect on the result.
- Back-to-back: Start held high continuously restarts one cycle after each Done rising edge.
- A and B are sampled only at the accepting edge; changes afterwards do not affect the result.
- All arithmetic is modulo 2^(tamanyo+1) on ACCU.
- The result is exact for all operand pairs, including (-2^(tamanyo-1))², which equals 2^(2*tamanyo-2).

Test Plan (tamanyo=8, t_mod=4):
1. Basic signs:
   - A=7, B=5, pulse Start → Done=1 exactly 17 cycles later, Producto=16'h0023.
   - A=-7, B=5 → Producto=16'hFFDD.
   - A=-7, B=-5 → 16'h0023.
2. Extreme operands:
   - A=-128, B=-128 → Producto=16'h4000.
   - A=-128, B=127 → 16'hC080.
   - A=127, B=127 → 16'h3F01.
   - A=0, B=-1 → 16'h0000.
3. Busy rejection: start 3×4; pulse Start with A=9, B=9 during cycle 6 → Producto=16'h000C, Done asserted once at cycle 17, no second result.
4. Reset mid-operation: start 100×3; drop RSTa asynchronously (between edges) at cycle 8 → Producto=0, Done=0 immediately. After release, start -2×3 → Producto=16'hFFFA after 17 cycles.
5. Done hold and back-to-back:
   - Hold Done 10 idle cycles → Producto stable.
   - Keep Start high across two operations (5×6, then A changed to -1 with B=6 after the first accept) → first Producto=16'h001E. Done drops on re-accept; second Producto=16'hFFFA, 18 cycles after the first.
6. Random: 10k random A, B, compared against a signed reference model. Also check Done timing and that changing A/B during busy has no effect.
